operand_assembler: RTL and testbench
====================================

OPERAND_ASSEMBLER -- requirements
Module: operand_assembler

Interface
REQ-001 Parameter: TIMEOUT_W, 16, width of inter-byte timeout counter; timeout = 2^TIMEOUT_W clk cycles.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: ena  input  1  block enable; low freezes FSM, counters and outputs.
REQ-005 Port: ui_in  input  8  operand data byte from pins.
REQ-006 Port: uio_in  input  8  control pins; [0] byte strobe, [1] start-of-frame, [7:2] ignored.
REQ-007 Port: core_busy  input  1  downstream eigen core cannot accept a new start.
REQ-008 Port: a0  output  32  signed operand alpha to core.
REQ-009 Port: a1  output  32  signed operand beta to core.
REQ-010 Port: start_calc  output  1  single-cycle start pulse to core.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: frame_err  output  1  sticky error flag; cleared by next start-of-frame.

Function
REQ-013 uio_in[0] and uio_in[1] SHALL each pass a 2-FF synchronizer, then rising-edge detection, giving one-cycle stb_rise and sof_rise.
REQ-014 ui_in SHALL be captured on the cycle stb_rise is high; sender holds data stable for at least 4 clk around the strobe edge.
REQ-015 FSM states SHALL be IDLE, LOAD, CHECK, WAIT_CORE, FIRE.
REQ-016 IDLE: sof_rise -> LOAD; byte_cnt=0, timeout counter=0, frame_err=0; stb_rise ignored.
REQ-017 LOAD: each stb_rise writes the byte into shadow register slot byte_cnt, then byte_cnt increments; bytes 0-3 form alpha and bytes 4-7 form beta, least-significant byte first.
REQ-018 After byte 7, LOAD SHALL go to CHECK when CHECKSUM_EN is defined, else to WAIT_CORE.
REQ-019 sof_rise in LOAD or CHECK SHALL restart the frame: byte_cnt=0, timeout reset; shadow is not cleared.
REQ-020 sof_rise and stb_rise in the same cycle: sof wins; the byte is discarded.
REQ-021 Timeout counter SHALL clear on every accepted byte; saturation in LOAD or CHECK sets frame_err=1 and returns to IDLE.
REQ-022 WAIT_CORE: stb_rise and sof_rise are ignored; when core_busy==0 -> FIRE.
REQ-023 FIRE: a0/a1 SHALL load from shadow atomically and start_calc=1 for exactly that cycle; next state IDLE.
REQ-024 start_calc SHALL assert exactly 1 cycle after the first WAIT_CORE cycle sampling core_busy==0.
REQ-025 a0/a1 SHALL change only in FIRE; an errored or aborted frame leaves them unchanged.
REQ-026 ena==0 SHALL hold state, counters and outputs, with start_calc forced 0; synchronizers keep running; edges occurring while ena==0 are lost.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, a0=0, a1=0, start_calc=0, busy=0, frame_err=0, byte_cnt=0, shadow=0, synchronizers=0.
REQ-028 Reset mid-frame or in WAIT_CORE SHALL abandon the frame with no start_calc pulse.

Configuration
REQ-029 Macro OPERAND_ASSEMBLER_CHECKSUM_EN: when defined, the frame carries a 9th byte (stb in CHECK) equal to the XOR of bytes 0-7; match -> WAIT_CORE, mismatch -> frame_err=1, IDLE. When undefined, CHECK is unreachable and frames are 8 bytes.

Verification
REQ-030 Frame sof, then bytes 78 56 34 12 F0 DE BC 9A with core_busy=0 -> a0=0x12345678, a1=0x9ABCDEF0, one start_calc pulse, busy low afterwards.
REQ-031 Same frame with core_busy=1 held 20 cycles after byte 7 -> start_calc exactly 1 cycle after core_busy falls; a0/a1 unchanged until then.
REQ-032 3 bytes, then sof, then full 8-byte frame 01..08 -> a0=0x04030201, a1=0x08070605; no extra pulse.
REQ-033 4 bytes, then idle for 2^16 cycles -> frame_err=1, IDLE, a0/a1 keep previous values, no start_calc.
REQ-034 With CHECKSUM_EN: bytes 01..08 with checksum 0x08 -> start_calc pulse; with checksum 0x09 -> frame_err=1, no pulse.
REQ-035 rst_n asserted after byte 5 -> all outputs 0 immediately; subsequent full frame loads correctly.

Source files
------------

// File: rtl/operand_assembler.sv
// Collects an 8-byte operand frame (alpha, beta; LSB first) from slow pins and hands it to the
// eigen core with a one-cycle start pulse. Optional 9th checksum byte: OPERAND_ASSEMBLER_CHECKSUM_EN.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start-of-frame; byte strobes ignored
// LOAD      | collecting bytes 0-7 into the shadow register
// CHECK     | waiting for the XOR checksum byte (checksum builds only)
// WAIT_CORE | frame complete, holding until the core is not busy
// FIRE      | a0/a1 updated from shadow, start_calc high for this cycle
module operand_assembler #(
    parameter int TIMEOUT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [7:0]  ui_in,
    input  logic [7:0]  uio_in,
    input  logic        core_busy,
    output logic [31:0] a0,
    output logic [31:0] a1,
    output logic        start_calc,
    output logic        busy,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_WAIT_CORE,
        S_FIRE
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             byte_cnt_q, byte_cnt_d;
    logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
    logic [63:0]            shadow_q, shadow_d;
    logic [31:0]            a0_q, a0_d;
    logic [31:0]            a1_q, a1_d;
    logic                   start_calc_q, start_calc_d;
    logic                   busy_q, busy_d;
    logic                   frame_err_q, frame_err_d;

    // [0]=strobe, [1]=start-of-frame; stage 3 is the previous synchronized value for edge detect
    logic [1:0]             sync1_q, sync2_q, sync3_q;
    logic                   stb_rise, sof_rise, tmo_sat;
    logic                   unused_uio;

    assign unused_uio = ^uio_in[7:2];
    assign stb_rise   = sync2_q[0] & ~sync3_q[0];
    assign sof_rise   = sync2_q[1] & ~sync3_q[1];
    assign tmo_sat    = &tmo_q;

`ifdef OPERAND_ASSEMBLER_CHECKSUM_EN
    logic [7:0] sum_calc;
    always_comb begin
        sum_calc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sum_calc = sum_calc ^ shadow_q[i*8 +: 8];
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        tmo_d        = tmo_q;
        shadow_d     = shadow_q;
        a0_d         = a0_q;
        a1_d         = a1_q;
        start_calc_d = start_calc_q;
        frame_err_d  = frame_err_q;
        busy_d       = busy_q;

        if (ena) begin
            start_calc_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sof_rise) begin
                        state_d     = S_LOAD;
                        byte_cnt_d  = 3'd0;
                        tmo_d       = '0;
                        frame_err_d = 1'b0;
                    end
                end
                S_LOAD: begin
                    if (sof_rise) begin
                        byte_cnt_d = 3'd0;
                        tmo_d      = '0;
                    end else if (stb_rise) begin
                        shadow_d[{byte_cnt_q, 3'b000} +: 8] = ui_in;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        tmo_d      = '0;
                        if (byte_cnt_q == 3'd7) begin
`ifdef OPERAND_ASSEMBLER_CHECKSUM_EN
                            state_d = S_CHECK;
`else
                            state_d = S_WAIT_CORE;
`endif
                        end
                    end else if (tmo_sat) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
`ifdef OPERAND_ASSEMBLER_CHECKSUM_EN
                S_CHECK: begin
                    if (sof_rise) begin
                        state_d    = S_LOAD;
                        byte_cnt_d = 3'd0;
                        tmo_d      = '0;
                    end else if (stb_rise) begin
                        tmo_d = '0;
                        if (ui_in == sum_calc) begin
                            state_d = S_WAIT_CORE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_IDLE;
                        end
                    end else if (tmo_sat) begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
`endif
                S_WAIT_CORE: begin
                    if (!core_busy) begin
                        state_d      = S_FIRE;
                        a0_d         = shadow_q[31:0];
                        a1_d         = shadow_q[63:32];
                        start_calc_d = 1'b1;
                    end
                end
                S_FIRE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
            busy_d = (state_d != S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= 3'd0;
            tmo_q        <= '0;
            shadow_q     <= 64'd0;
            a0_q         <= 32'd0;
            a1_q         <= 32'd0;
            start_calc_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            sync1_q      <= 2'b00;
            sync2_q      <= 2'b00;
            sync3_q      <= 2'b00;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            tmo_q        <= tmo_d;
            shadow_q     <= shadow_d;
            a0_q         <= a0_d;
            a1_q         <= a1_d;
            start_calc_q <= start_calc_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
            sync1_q      <= uio_in[1:0];
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
        end
    end

    // A pulse held over by ena going low is released once ena returns
    assign start_calc = start_calc_q & ena;
    assign a0         = a0_q;
    assign a1         = a1_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_operand_assembler.sv
// Directed and randomized frames against a frame-level reference model of operand_assembler.
module tb_operand_assembler;

    localparam int TW = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        core_busy = 1'b0;
    logic [7:0]  ui_in = 8'h00;
    logic [7:0]  uio_in = 8'h00;
    logic [31:0] a0, a1;
    logic        start_calc, busy, frame_err;

    int          n_tests = 0;
    int          n_fail = 0;
    int          pulse_cnt = 0;
    int          viol = 0;
    int          exp_pulses = 0;
    logic [31:0] exp_a0 = 32'd0;
    logic [31:0] exp_a1 = 32'd0;
    logic [31:0] prev_a0 = 32'd0;
    logic [31:0] prev_a1 = 32'd0;
    logic        prev_sc = 1'b0;
    logic [7:0]  fb [8];

    always #5 clk = ~clk;

    operand_assembler #(.TIMEOUT_W(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .ui_in      (ui_in),
        .uio_in     (uio_in),
        .core_busy  (core_busy),
        .a0         (a0),
        .a1         (a1),
        .start_calc (start_calc),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    // Pulses are counted, and a0/a1 may only move together with a pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (start_calc) pulse_cnt <= pulse_cnt + 1;
            if ((start_calc && prev_sc) ||
                (!start_calc && (a0 !== prev_a0 || a1 !== prev_a1))) viol <= viol + 1;
        end
        prev_a0 <= a0;
        prev_a1 <= a1;
        prev_sc <= start_calc;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_sof();
        @(negedge clk);
        uio_in[1] = 1'b1;
        tick(4);
        uio_in[1] = 1'b0;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ui_in = b;
        tick(2);
        uio_in[0] = 1'b1;
        tick(4);
        uio_in[0] = 1'b0;
        tick(4);
    endtask

    function automatic logic [7:0] xsum();
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 8; i++) s = s ^ fb[i];
        return s;
    endfunction

    // Frame: sof, bytes fb[0..7], then the checksum byte when the feature is built in
    task automatic send_frame(input logic bad_sum);
        send_sof();
        for (int i = 0; i < 8; i++) send_byte(fb[i]);
`ifdef OPERAND_ASSEMBLER_CHECKSUM_EN
        send_byte(xsum() ^ {7'd0, bad_sum});
`else
        if (bad_sum) send_byte(8'h5A);
`endif
    endtask

    // Reference: a completed frame delivers its bytes LSB-first to a0/a1 with one pulse
    task automatic model_accept();
        exp_a0 = {fb[3], fb[2], fb[1], fb[0]};
        exp_a1 = {fb[7], fb[6], fb[5], fb[4]};
        exp_pulses++;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_a0"}, a0, exp_a0);
        check({tag, "_a1"}, a1, exp_a1);
        check({tag, "_pulses"}, pulse_cnt, exp_pulses);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic set_frame(input logic [63:0] v);
        for (int i = 0; i < 8; i++) fb[i] = v[i*8 +: 8];
    endtask

    initial begin
        tick(3);
        check("rst_a0", a0, 32'd0);
        check("rst_a1", a1, 32'd0);
        check("rst_sc", start_calc, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        rst_n = 1'b1;
        tick(2);

        send_byte(8'hAA);
        check("idle_stb_busy", busy, 1'b0);

        set_frame(64'h9ABCDEF0_12345678);
        send_frame(1'b0);
        tick(20);
        model_accept();
        check("basic_a0_const", a0, 32'h12345678);
        check("basic_a1_const", a1, 32'h9ABCDEF0);
        check_idle("basic");

        core_busy = 1'b1;
        set_frame(64'h88776655_44332211);
        send_frame(1'b0);
        tick(20);
        check("hold_busy", busy, 1'b1);
        check("hold_sc", start_calc, 1'b0);
        check("hold_a0", a0, exp_a0);
        check("hold_a1", a1, exp_a1);
        core_busy = 1'b0;
        @(negedge clk);
        model_accept();
        check("rel_sc", start_calc, 1'b1);
        check("rel_a0", a0, exp_a0);
        check("rel_a1", a1, exp_a1);
        tick(5);
        check_idle("rel");

        send_sof();
        for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i));
        set_frame(64'h08070605_04030201);
        send_frame(1'b0);
        tick(20);
        model_accept();
        check("abort_a0_const", a0, 32'h04030201);
        check_idle("abort");

        set_frame(64'h0F1E2D3C_4B5A6978);
        send_sof();
        for (int i = 0; i < 3; i++) send_byte(fb[i]);
        ena = 1'b0;
        send_byte(8'hEE);
        check("ena_hold_busy", busy, 1'b1);
        ena = 1'b1;
        for (int i = 3; i < 8; i++) send_byte(fb[i]);
`ifdef OPERAND_ASSEMBLER_CHECKSUM_EN
        send_byte(xsum());
`endif
        tick(20);
        model_accept();
        check_idle("ena");

`ifdef OPERAND_ASSEMBLER_CHECKSUM_EN
        set_frame(64'h08070605_04030201);
        send_frame(1'b0);
        tick(20);
        model_accept();
        check_idle("sum_ok");
        check("sum_ok_ferr", frame_err, 1'b0);
        send_frame(1'b1);
        tick(20);
        check_idle("sum_bad");
        check("sum_bad_ferr", frame_err, 1'b1);
`endif

        for (int it = 0; it < 10; it++) begin
            int hold;
            for (int i = 0; i < 8; i++) fb[i] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) begin
                send_sof();
                for (int i = 0; i < int'($urandom_range(1, 7)); i++)
                    send_byte(8'($urandom_range(0, 255)));
            end
            hold = int'($urandom_range(0, 8));
            core_busy = (hold > 0);
            send_frame(1'b0);
            tick(hold);
            core_busy = 1'b0;
            tick(20);
            model_accept();
            check_idle("rand");
        end

        set_frame(64'h0);
        send_sof();
        for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i));
        tick((1 << TW) - 64);
        check("tmo_early_ferr", frame_err, 1'b0);
        check("tmo_early_busy", busy, 1'b1);
        tick(128);
        check("tmo_ferr", frame_err, 1'b1);
        check_idle("tmo");
        send_sof();
        tick(2);
        check("tmo_clr_ferr", frame_err, 1'b0);
        check("tmo_clr_busy", busy, 1'b1);

        set_frame(64'hCAFEBABE_DEADBEEF);
        send_sof();
        for (int i = 0; i < 6; i++) send_byte(fb[i]);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_a0 = 32'd0;
        exp_a1 = 32'd0;
        check("mrst_a0", a0, 32'd0);
        check("mrst_a1", a1, 32'd0);
        check("mrst_sc", start_calc, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_ferr", frame_err, 1'b0);
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check_idle("mrst_after");
        set_frame(64'h13579BDF_2468ACE0);
        send_frame(1'b0);
        tick(20);
        model_accept();
        check_idle("post_rst");

        check("monitor_viol", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
